// File: rtl/line_steer_ctrl.sv
// Line-follow steering controller: turns per-frame centroid results into a saturated
// servo command with dropout hold / loss stop, and drives a glitch-free servo PWM.
module line_steer_ctrl #(
  parameter int IMG_W        = 640,
  parameter int PWM_PERIOD   = 1000000,
  parameter int SERVO_MIN    = 50000,
  parameter int SERVO_CENTER = 75000,
  parameter int SERVO_MAX    = 100000,
  parameter int KP_NUM       = 78,
  parameter int KP_SHIFT     = 0,
  parameter int DEADBAND     = 8,
  parameter int LOST_LIMIT   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic [10:0]                     centroid_x,
  input  logic                            line_valid,
  input  logic                            line_lost,
  output logic [$clog2(PWM_PERIOD+1)-1:0] steer_cmd,
  output logic                            servo_pwm,
  output logic                            motor_en,
  output logic [1:0]                      state,
  output logic [11:0]                     error_px
);

  localparam int W  = $clog2(PWM_PERIOD + 1);
  localparam int CW = $clog2(LOST_LIMIT + 1);
  localparam logic [W-1:0] CENTER   = W'(SERVO_CENTER);
  localparam logic [W-1:0] PWM_LAST = W'(PWM_PERIOD - 1);

  if (!(SERVO_MIN <= SERVO_CENTER && SERVO_CENTER <= SERVO_MAX && SERVO_MAX <= PWM_PERIOD))
  begin : g_bad_servo_bounds
    $error("line_steer_ctrl: servo bounds must satisfy MIN <= CENTER <= MAX <= PWM_PERIOD");
  end
  if (LOST_LIMIT < 1 || KP_SHIFT < 0 || KP_SHIFT > 15 || KP_NUM < 0 || KP_NUM > 255)
  begin : g_bad_ctrl_params
    $error("line_steer_ctrl: LOST_LIMIT >= 1, KP_SHIFT in 0..15, KP_NUM in 0..255");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_HOLD  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Clamp to the image, centre on the setpoint, and zero small errors.
  function automatic logic signed [11:0] deadband_err(input logic [10:0] x);
    logic signed [31:0] cx;
    logic signed [31:0] d;
    cx = $signed({21'd0, x});
    if (cx > IMG_W - 1) cx = IMG_W - 1;
    d = cx - IMG_W / 2;
    if (d <= DEADBAND && d >= -DEADBAND) d = 0;
    return 12'(d);
  endfunction

  function automatic logic signed [31:0] scale_err(input logic signed [11:0] e);
    logic signed [31:0] prod;
    prod = $signed({{20{e[11]}}, e}) * KP_NUM;
    return prod >>> KP_SHIFT;
  endfunction

  function automatic logic [W-1:0] sat_servo(input logic signed [31:0] t);
    logic signed [31:0] s;
    s = t;
    if (s < SERVO_MIN) s = SERVO_MIN;
    else if (s > SERVO_MAX) s = SERVO_MAX;
    return W'(s);
  endfunction

  // ---- stage 0 -> 1: frame acceptance and deadbanded error ----
  logic               vld_p1;
  logic               lost_p1;
  logic signed [11:0] err_p1;

  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= line_valid & enable;
  end

  always_ff @(posedge clk) begin
    if (line_valid) begin
      lost_p1 <= line_lost;
      err_p1  <= deadband_err(centroid_x);
    end
  end

  // ---- stage 1 -> 2: gain, saturation and tracking FSM ----
  logic [W-1:0] tgt;
  assign tgt = sat_servo(SERVO_CENTER + scale_err(err_p1));

  state_t             state_q, state_d;
  logic [CW-1:0]      lost_q, lost_d;
  logic [W-1:0]       steer_q, steer_d;
  logic signed [11:0] err_q, err_d;
  logic               motor_q, motor_d;
  int                 lost_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lost_q  <= '0;
      steer_q <= CENTER;
      err_q   <= '0;
      motor_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lost_q  <= lost_d;
      steer_q <= steer_d;
      err_q   <= err_d;
      motor_q <= motor_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lost_d   = lost_q;
    steer_d  = steer_q;
    err_d    = err_q;
    lost_inc = (state_q == S_TRACK) ? 1 : int'(lost_q) + 1;
    if (!enable) begin
      // Dropping enable also discards whatever frame is still in flight.
      state_d = S_IDLE;
      lost_d  = '0;
      steer_d = CENTER;
    end else if (vld_p1) begin
      if (!lost_p1) begin
        state_d = S_TRACK;
        lost_d  = '0;
        steer_d = tgt;
        err_d   = err_p1;
      end else begin
        case (state_q)
          S_TRACK, S_HOLD: begin
            if (lost_inc >= LOST_LIMIT) begin
              state_d = S_STOP;
              lost_d  = CW'(LOST_LIMIT);
              steer_d = CENTER;
            end else begin
              state_d = S_HOLD;
              lost_d  = CW'(lost_inc);
            end
          end
          S_STOP: lost_d = CW'(LOST_LIMIT);
          default: ;
        endcase
      end
    end
    motor_d = (state_d == S_TRACK) || (state_d == S_HOLD);
  end

  // ---- PWM: width only reloads at the period boundary ----
  logic [W-1:0] pcnt_q, pcnt_d;
  logic [W-1:0] width_q, width_d;
  logic         pwm_q, pwm_d;
  logic         wrap;

  always_comb begin
    wrap    = (pcnt_q == PWM_LAST);
    pcnt_d  = wrap ? '0 : pcnt_q + W'(1);
    width_d = wrap ? steer_q : width_q;
    pwm_d   = (pcnt_q < width_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q  <= '0;
      width_q <= CENTER;
      pwm_q   <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      width_q <= width_d;
      pwm_q   <= pwm_d;
    end
  end

  assign steer_cmd = steer_q;
  assign servo_pwm = pwm_q;
  assign motor_en  = motor_q;
  assign state     = state_q;
  assign error_px  = err_q;

endmodule

// File: tb/tb_line_steer_ctrl.sv
// Directed + randomized bench for line_steer_ctrl against a frame-level reference model.
module tb_line_steer_ctrl;

  localparam int IMG_W        = 640;
  localparam int P            = 1000;
  localparam int SERVO_MIN    = 100;
  localparam int SERVO_CENTER = 150;
  localparam int SERVO_MAX    = 200;
  localparam int KP_NUM       = 1;
  localparam int KP_SHIFT     = 2;
  localparam int DEADBAND     = 8;
  localparam int LOST_LIMIT   = 3;
  localparam int W            = $clog2(P + 1);

  logic         clk = 1'b0;
  logic         rst, enable, line_valid, line_lost;
  logic [10:0]  centroid_x;
  logic [W-1:0] steer_cmd;
  logic         servo_pwm, motor_en;
  logic [1:0]   state;
  logic [11:0]  error_px;

  line_steer_ctrl #(
    .IMG_W(IMG_W), .PWM_PERIOD(P), .SERVO_MIN(SERVO_MIN), .SERVO_CENTER(SERVO_CENTER),
    .SERVO_MAX(SERVO_MAX), .KP_NUM(KP_NUM), .KP_SHIFT(KP_SHIFT), .DEADBAND(DEADBAND),
    .LOST_LIMIT(LOST_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .centroid_x(centroid_x),
    .line_valid(line_valid), .line_lost(line_lost), .steer_cmd(steer_cmd),
    .servo_pwm(servo_pwm), .motor_en(motor_en), .state(state), .error_px(error_px)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: 0=IDLE 1=TRACK 2=HOLD 3=STOP
  int m_state = 0;
  int m_steer = SERVO_CENTER;
  int m_err   = 0;
  int m_lost  = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_err(input int c);
    int cc, e, mag;
    cc  = (c > IMG_W - 1) ? IMG_W - 1 : c;
    e   = cc - IMG_W / 2;
    mag = (e < 0) ? -e : e;
    return (mag <= DEADBAND) ? 0 : e;
  endfunction

  function automatic int ref_tgt(input int e);
    int num, den, q, t;
    num = e * KP_NUM;
    den = 1 << KP_SHIFT;
    q   = num / den;
    if (num % den != 0 && num < 0) q = q - 1;
    t = SERVO_CENTER + q;
    if (t < SERVO_MIN) t = SERVO_MIN;
    if (t > SERVO_MAX) t = SERVO_MAX;
    return t;
  endfunction

  task automatic model_frame(input bit lost, input int c);
    if (!lost) begin
      m_err   = ref_err(c);
      m_steer = ref_tgt(m_err);
      m_state = 1;
      m_lost  = 0;
    end else if (m_state == 1 || m_state == 2) begin
      m_lost = m_lost + 1;
      if (m_lost >= LOST_LIMIT) begin
        m_state = 3;
        m_steer = SERVO_CENTER;
        m_lost  = LOST_LIMIT;
      end else begin
        m_state = 2;
      end
    end
  endtask

  task automatic model_disable();
    m_state = 0;
    m_steer = SERVO_CENTER;
    m_lost  = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".state"}, state, m_state);
    chk({tag, ".steer"}, steer_cmd, m_steer);
    chk({tag, ".err"}, $signed(error_px), m_err);
    chk({tag, ".motor"}, motor_en, (m_state == 1 || m_state == 2) ? 1 : 0);
  endtask

  // Frame strobe at one negedge; results are checked two clocks later.
  task automatic send_frame(input string tag, input bit lost, input int c);
    @(negedge clk);
    line_valid = 1'b1;
    line_lost  = lost;
    centroid_x = 11'(c);
    @(negedge clk);
    line_valid = 1'b0;
    centroid_x = 11'($urandom_range(0, 2047));
    @(negedge clk);
    model_frame(lost, c);
    check_outputs(tag);
  endtask

  // Returns the number of low samples before the next rising edge of servo_pwm.
  task automatic wait_rise(output int low_cnt);
    int guard;
    guard   = 0;
    low_cnt = 0;
    while (servo_pwm === 1'b1 && guard < 2 * P) begin
      @(negedge clk);
      guard++;
    end
    while (servo_pwm !== 1'b1 && guard < 2 * P) begin
      @(negedge clk);
      low_cnt++;
      guard++;
    end
    chk("rise_bound", guard >= 2 * P, 0);
  endtask

  task automatic measure_high(output int hi);
    hi = 0;
    while (servo_pwm === 1'b1 && hi < 2 * P) begin
      hi++;
      @(negedge clk);
    end
    chk("high_bound", hi >= 2 * P, 0);
  endtask

  task automatic next_pulse(output int hi, output int lo);
    wait_rise(lo);
    measure_high(hi);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, lo, hi_a, h2;
    bit lost;
    int c;

    rst = 1'b1; enable = 1'b0; line_valid = 1'b0; line_lost = 1'b0; centroid_x = '0;

    // 1: reset values and free-running centred PWM
    repeat (3) begin
      @(negedge clk);
      chk("rst.pwm", servo_pwm, 0);
    end
    check_outputs("rst");
    rst = 1'b0;
    @(negedge clk);
    measure_high(hi);
    chk("rst.first_hi", hi, 150);
    wait_rise(lo);
    chk("rst.low", lo, 850);
    measure_high(hi);
    chk("rst.second_hi", hi, 150);

    // 2: tracking with two-cycle latency
    enable = 1'b1;
    @(negedge clk);
    line_valid = 1'b1; line_lost = 1'b0; centroid_x = 11'd360;
    @(negedge clk);
    line_valid = 1'b0;
    chk("lat.steer", steer_cmd, 150);
    chk("lat.state", state, 0);
    @(negedge clk);
    model_frame(1'b0, 360);
    check_outputs("f360");
    chk("f360.lit", steer_cmd, 160);
    next_pulse(hi, lo);
    chk("f360.pulse", hi, 160);
    next_pulse(hi, lo);
    chk("f360.pulse2", hi, 160);
    chk("f360.low2", lo, 840);
    send_frame("f325", 1'b0, 325);
    chk("f325.lit", steer_cmd, 150);

    // 3: saturation and clamping
    send_frame("f639", 1'b0, 639);
    chk("f639.lit", steer_cmd, 200);
    send_frame("f2047", 1'b0, 2047);
    chk("f2047.lit", steer_cmd, 200);
    send_frame("f0", 1'b0, 0);
    chk("f0.lit", steer_cmd, 100);

    // 4: loss sequence
    send_frame("l.track", 1'b0, 360);
    send_frame("l.lost1", 1'b1, 17);
    send_frame("l.lost2", 1'b1, 900);
    chk("l.lost2.lit", state, 2);
    send_frame("l.lost3", 1'b1, 360);
    chk("l.lost3.lit", state, 3);
    chk("l.lost3.steer", steer_cmd, 150);
    send_frame("l.found", 1'b0, 300);
    chk("l.found.steer", steer_cmd, 145);
    chk("l.found.err", $signed(error_px), -20);

    // 5: steer change landing exactly on the PWM wrap
    send_frame("w.setup", 1'b0, 320);
    wait_rise(lo);
    hi_a = 1;
    for (int k = 1; k <= P - 3; k++) begin
      @(negedge clk);
      if (servo_pwm === 1'b1) hi_a++;
    end
    line_valid = 1'b1; line_lost = 1'b0; centroid_x = 11'd480;
    @(negedge clk);
    line_valid = 1'b0;
    chk("w.pre.steer", steer_cmd, 150);
    @(negedge clk);
    model_frame(1'b0, 480);
    check_outputs("w.f480");
    chk("w.cur_hi", hi_a, 150);
    next_pulse(hi, lo);
    chk("w.next_hi", hi, 150);
    next_pulse(hi, lo);
    chk("w.after_hi", hi, 190);
    chk("w.after_lo", lo, 850);

    // 6: enable drop with a frame in flight, then reset mid-pulse
    wait_rise(lo);
    repeat (9) @(negedge clk);
    line_valid = 1'b1; line_lost = 1'b0; centroid_x = 11'd0;
    @(negedge clk);
    line_valid = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    model_disable();
    check_outputs("dis.t1");
    @(negedge clk);
    check_outputs("dis.t2");
    measure_high(h2);
    chk("dis.cur_hi", 12 + h2, 190);
    next_pulse(hi, lo);
    chk("dis.next_hi", hi, 150);
    chk("dis.next_lo", lo, 810);

    wait_rise(lo);
    repeat (20) @(negedge clk);
    chk("rmid.pre", servo_pwm, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rmid.pwm", servo_pwm, 0);
    m_state = 0; m_steer = SERVO_CENTER; m_err = 0; m_lost = 0;
    check_outputs("rmid");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    measure_high(hi);
    chk("rmid.restart_hi", hi, 150);

    // Randomized frames checked against the model
    enable = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        model_disable();
        check_outputs("rnd.dis");
        enable = 1'b1;
      end else begin
        lost = ($urandom_range(0, 9) < 4);
        c = ($urandom_range(0, 9) == 0) ? int'($urandom_range(640, 2047))
                                         : int'($urandom_range(0, 639));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_frame("rnd", lost, c);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
